// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl -- sequencing control for an iterative multiply/divide unit.
//
// Decodes mul/div in the execute stage, fires a one-cycle start pulse to the
// datapath, enables ITER datapath iterations, stalls the pipeline while the
// datapath runs, then issues a single writeback pulse with either the normal
// destination register or an exception write to r30 carrying an rstatus code.
//
// Parameters:
//   ITER          datapath iterations per operation (2..63)
// Optional build macro:
//   MULTDIV_EARLY_ZERO_EN  a div whose divisor is zero at start skips the
//                          iteration phase and writes back the exception on
//                          the very next cycle.
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   dec_valid     execute-stage instruction valid
//   opcode        execute-stage opcode [4:0]
//   ALUop         execute-stage ALU op field [4:0]
//   rd            execute-stage destination register [4:0]
//   divisor_zero  operand B is zero
//   ovf_in        datapath multiply overflow flag (used in DONE only)
//   flush         pipeline flush (taken branch/jump)
//   ctrl_mult     one-cycle multiply start pulse
//   ctrl_div      one-cycle divide start pulse
//   step_en       datapath iteration enable
//   md_busy       pipeline stall request
//   wb_en         one-cycle writeback pulse
//   wb_rd         writeback register [4:0]
//   status_val    rstatus code [2:0]
//   exc           writeback is an exception write
module multdiv_ctrl #(
  parameter int unsigned ITER = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] opcode,
  input  logic [4:0] ALUop,
  input  logic [4:0] rd,
  input  logic       divisor_zero,
  input  logic       ovf_in,
  input  logic       flush,
  output logic       ctrl_mult,
  output logic       ctrl_div,
  output logic       step_en,
  output logic       md_busy,
  output logic       wb_en,
  output logic [4:0] wb_rd,
  output logic [2:0] status_val,
  output logic       exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);
  localparam logic [4:0] EXC_REG  = 5'd30;
  localparam logic [2:0] ST_MUL   = 3'd4;
  localparam logic [2:0] ST_DIV   = 3'd5;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       op_div_q, op_div_d;   // 1 = div, 0 = mul
  logic [4:0] rd_q, rd_d;
  logic       dz_q, dz_d;

  logic is_mul, is_div, start;

  assign is_mul = (opcode == 5'b00000) && (ALUop == 5'b00110);
  assign is_div = (opcode == 5'b00000) && (ALUop == 5'b00111);

  // Gated with reset so the combinational start pulses stay low while reset
  // is held, even if a valid mul/div is sitting in execute.
  assign start = dec_valid && (is_mul || is_div) && (state_q == IDLE) &&
                 !flush && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_div_q <= 1'b0;
      rd_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_div_q <= op_div_d;
      rd_q     <= rd_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_div_d   = op_div_q;
    rd_d       = rd_q;
    dz_d       = dz_q;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    step_en    = 1'b0;
    md_busy    = 1'b0;
    wb_en      = 1'b0;
    wb_rd      = '0;
    status_val = '0;
    exc        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ctrl_mult = is_mul;
          ctrl_div  = is_div;
          md_busy   = 1'b1;
          op_div_d  = is_div;
          rd_d      = rd;
          dz_d      = divisor_zero;
          count_d   = '0;
`ifdef MULTDIV_EARLY_ZERO_EN
          // Result is already known to be an exception; skip the iterations.
          state_d   = (is_div && divisor_zero) ? DONE : RUN;
`else
          state_d   = RUN;
`endif
        end
      end

      RUN: begin
        step_en = 1'b1;
        md_busy = 1'b1;
        if (flush) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == LAST_CNT) begin
          state_d = DONE;
          count_d = '0;
        end else begin
          count_d = count_q + 6'd1;
        end
      end

      DONE: begin
        // md_busy stays low here so the stalled instruction advances while
        // the result is written back.
        state_d = IDLE;
        if (!flush) begin
          wb_en = 1'b1;
          exc   = op_div_q ? dz_q : ovf_in;
          if (exc) begin
            wb_rd      = EXC_REG;
            status_val = op_div_q ? ST_DIV : ST_MUL;
          end else begin
            wb_rd      = rd_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

  localparam int ITER = 32;

  logic       clock;
  logic       reset;
  logic       dec_valid;
  logic [4:0] opcode;
  logic [4:0] ALUop;
  logic [4:0] rd;
  logic       divisor_zero;
  logic       ovf_in;
  logic       flush;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       step_en;
  logic       md_busy;
  logic       wb_en;
  logic [4:0] wb_rd;
  logic [2:0] status_val;
  logic       exc;

  multdiv_ctrl #(.ITER(ITER)) dut (
    .clock        (clock),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .opcode       (opcode),
    .ALUop        (ALUop),
    .rd           (rd),
    .divisor_zero (divisor_zero),
    .ovf_in       (ovf_in),
    .flush        (flush),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .step_en      (step_en),
    .md_busy      (md_busy),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .status_val   (status_val),
    .exc          (exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_div   = 0;

  typedef struct {
    int         c;
    logic [4:0] r;
    logic [2:0] st;
    logic       ex;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [4:0] r, input logic [2:0] st, input logic ex);
    exp_t e;
    e.c = c; e.r = r; e.st = st; e.ex = ex;
    exp_q.push_back(e);
  endtask

  // Writeback scoreboard and start-pulse counter, sampled mid-cycle.
  always @(negedge clock) begin
    if (wb_en) begin
      if (exp_q.size() == 0) begin
        check("unexp_wb", 32'd1, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("wb_cyc", cyc, e_mon.c);
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e_mon.r});
        check("wb_status", {29'd0, status_val}, {29'd0, e_mon.st});
        check("wb_exc", {31'd0, exc}, {31'd0, e_mon.ex});
      end
    end else begin
      check("wb_idle", {23'd0, exc, wb_rd, status_val}, 32'd0);
    end
    if (ctrl_div) n_div++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic is_div, input logic [4:0] r, input logic dz);
    dec_valid    = 1'b1;
    opcode       = 5'b00000;
    ALUop        = is_div ? 5'b00111 : 5'b00110;
    rd           = r;
    divisor_zero = dz;
  endtask

  // Follows an accepted operation from the cycle after start to DONE (lat
  // cycles later), then one idle cycle. ovf_in is the opposite of ovf_done
  // everywhere except the DONE cycle.
  task automatic follow(input int lat, input logic ovf_done, input logic hold, input logic [4:0] r);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (!hold) begin
        dec_valid    = 1'b0;
        rd           = ~r;
        divisor_zero = 1'b0;
      end
      ovf_in = (k == lat) ? ovf_done : ~ovf_done;
      @(negedge clock);
      check("ctrl_quiet", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
      check("step_en", {31'd0, step_en}, {31'd0, (k < lat)});
      check("md_busy", {31'd0, md_busy}, {31'd0, (k < lat)});
    end
    tick();
    dec_valid = 1'b0;
    ovf_in    = 1'b0;
    @(negedge clock);
    check("idle_after", {29'd0, md_busy, ctrl_mult, ctrl_div}, 32'd0);
  endtask

  task automatic run_op(input logic is_div, input logic [4:0] r, input logic dz,
                        input logic ovf_done, input logic hold);
    int lat;
    logic ex;
    lat = ITER + 1;
`ifdef MULTDIV_EARLY_ZERO_EN
    if (is_div && dz) lat = 1;
`endif
    ex = is_div ? dz : ovf_done;
    tick();
    drive_op(is_div, r, dz);
    push_exp(cyc + lat, ex ? 5'd30 : r, ex ? (is_div ? 3'd5 : 3'd4) : 3'd0, ex);
    @(negedge clock);
    check("start_pulse", {30'd0, ctrl_mult, ctrl_div}, {30'd0, !is_div, is_div});
    check("start_busy", {31'd0, md_busy}, 32'd1);
    follow(lat, ovf_done, hold, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int div_before;
    reset        = 1'b1;
    flush        = 1'b0;
    ovf_in       = 1'b1;
    drive_op(1'b0, 5'd7, 1'b0);
    #3;
    check("rst_outputs", {17'd0, ctrl_mult, ctrl_div, step_en, md_busy, wb_en, exc, wb_rd, status_val}, 32'd0);
    tick();
    reset     = 1'b0;
    dec_valid = 1'b0;
    ovf_in    = 1'b0;
    @(negedge clock);
    check("post_rst_idle", {30'd0, md_busy, step_en}, 32'd0);

    // mul rd=7, no overflow (ovf_in high during RUN must be ignored)
    run_op(1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    // mul with overflow seen only in DONE
    run_op(1'b0, 5'd12, 1'b0, 1'b1, 1'b0);
    // div, nonzero divisor, ovf_in high in DONE ignored
    run_op(1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
    // div by zero
    run_op(1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    // div with dec_valid held through DONE
    div_before = n_div;
    run_op(1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    check("single_div_pulse", n_div - div_before, 32'd1);

    // flush at T+10 during RUN, new mul accepted at T+11
    tick();
    drive_op(1'b0, 5'd4, 1'b0);
    @(negedge clock);
    check("fl_start", {31'd0, ctrl_mult}, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      dec_valid = 1'b0;
      flush     = (k == 10);
      @(negedge clock);
    end
    check("fl_run_busy", {30'd0, md_busy, step_en}, 32'd3);
    tick();
    flush = 1'b0;
    drive_op(1'b0, 5'd11, 1'b0);
    push_exp(cyc + ITER + 1, 5'd11, 3'd0, 1'b0);
    @(negedge clock);
    check("fl_restart", {31'd0, ctrl_mult}, 32'd1);
    follow(ITER + 1, 1'b0, 1'b0, 5'd11);

    // flush coinciding with a start condition in IDLE
    tick();
    drive_op(1'b0, 5'd3, 1'b0);
    flush = 1'b1;
    @(negedge clock);
    check("fl_coincide", {30'd0, ctrl_mult, md_busy}, 32'd0);
    tick();
    dec_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clock);
    check("fl_no_run", {30'd0, step_en, md_busy}, 32'd0);

    // reset pulsed at T+5 during RUN
    tick();
    drive_op(1'b0, 5'd6, 1'b0);
    @(negedge clock);
    check("rr_start", {31'd0, ctrl_mult}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      dec_valid = 1'b0;
      @(negedge clock);
    end
    tick();
    reset = 1'b1;
    drive_op(1'b0, 5'd6, 1'b0);
    #1;
    check("rr_async", {17'd0, ctrl_mult, ctrl_div, step_en, md_busy, wb_en, exc, wb_rd, status_val}, 32'd0);
    @(negedge clock);
    check("rr_hold", {17'd0, ctrl_mult, ctrl_div, step_en, md_busy, wb_en, exc, wb_rd, status_val}, 32'd0);
    tick();
    reset = 1'b0;
    drive_op(1'b0, 5'd13, 1'b0);
    push_exp(cyc + ITER + 1, 5'd13, 3'd0, 1'b0);
    @(negedge clock);
    check("rr_restart", {31'd0, ctrl_mult}, 32'd1);
    follow(ITER + 1, 1'b0, 1'b0, 5'd13);

    repeat (3) tick();
    check("pending_wb", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
